// File: rtl/ps2_key_event_queue.sv
// PS/2 byte parser with held-key map, repeat filter
// and a make/break event FIFO with valid/ready output.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH    = 8,
  parameter bit FILTER_REPEAT = 1'b1,
  parameter bit REQUIRE_BAT   = 1'b1,
  parameter int TIMEOUT_CYC   = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_err,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_break,
  output logic [8:0]                    evt_code,
  output logic [511:0]                  key_down,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          kb_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_WAIT_BAT,
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmr_q;
  logic          emit, emit_brk;
  logic [8:0]    emit_code;
  logic          rebat, bat_ok, in_pfx;
  logic          ign;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          accept, pop, push, full, drop;

  assign in_pfx = (state_q == S_EXT) || (state_q == S_BRK) ||
                  (state_q == S_EXTBRK) || (state_q == S_PAUSE);
  assign ign = (byte_data == 8'h00) || (byte_data == 8'hFF) ||
               (byte_data == 8'hFA) || (byte_data == 8'hFE) ||
               (byte_data == 8'hEE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= REQUIRE_BAT ? S_WAIT_BAT : S_IDLE;
      skip_q   <= '0;
      tmr_q    <= '0;
      kb_ready <= !REQUIRE_BAT;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (bat_ok) kb_ready <= 1'b1;
      if (byte_valid || byte_err || !in_pfx) tmr_q <= '0;
      else tmr_q <= tmr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_code = '0;
    rebat     = 1'b0;
    bat_ok    = 1'b0;
    if (byte_err) begin
      if (state_q != S_WAIT_BAT) state_d = S_IDLE;
    end else if (byte_valid) begin
      unique case (state_q)
        S_WAIT_BAT: begin
          if (byte_data == 8'hAA) begin
            state_d = S_IDLE;
            bat_ok  = 1'b1;
          end
        end
        S_IDLE: begin
          unique case (1'b1)
            byte_data == 8'hE0: state_d = S_EXT;
            byte_data == 8'hF0: state_d = S_BRK;
            byte_data == 8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            byte_data == 8'hAA: rebat = 1'b1;
            ign: ;
            default: begin
              emit      = 1'b1;
              emit_code = {1'b0, byte_data};
            end
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            byte_data == 8'hF0: state_d = S_EXTBRK;
            byte_data == 8'hE0: ;
            default: begin
              emit      = 1'b1;
              emit_code = {1'b1, byte_data};
              state_d   = S_IDLE;
            end
          endcase
        end
        S_BRK, S_EXTBRK: begin
          emit      = 1'b1;
          emit_brk  = 1'b1;
          emit_code = {state_q == S_EXTBRK, byte_data};
          state_d   = S_IDLE;
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit      = 1'b1;
            emit_code = 9'h0E1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (in_pfx && tmr_q == TMO) begin
      state_d = S_IDLE;
    end
  end

  // repeat makes of a held key vanish before touching map or FIFO
  assign accept = emit &&
                  !(FILTER_REPEAT && !emit_brk && key_down[emit_code]);
  assign pop  = evt_valid && evt_ready;
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_down <= '0;
      overflow <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (rebat) key_down <= '0;
      else if (accept) key_down[emit_code] <= !emit_brk;
      if (drop) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (push) begin
        mem[wr_q] <= {emit_brk, emit_code};
        wr_q      <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign evt_valid              = (cnt_q != '0);
  assign {evt_break, evt_code}  = mem[rd_q];
  assign fifo_count             = cnt_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed scenarios plus random
// byte streams against a byte-level queue/map reference model.
module tb_ps2_key_event_queue;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;
  localparam bit FR    = 1'b1;

  localparam int M_WAIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_EXT   = 2;
  localparam int M_BRK   = 3;
  localparam int M_EBRK  = 4;
  localparam int M_PAUSE = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         byte_valid, byte_err, evt_ready, overflow_clr;
  logic [7:0]   byte_data;
  logic         evt_valid, evt_break, overflow, kb_ready;
  logic [8:0]   evt_code;
  logic [511:0] key_down;
  logic [3:0]   fifo_count;

  always #5 clk = ~clk;

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH),
    .FILTER_REPEAT(FR),
    .REQUIRE_BAT(1'b1),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_err(byte_err),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_break(evt_break),
    .evt_code(evt_code),
    .key_down(key_down),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .overflow_clr(overflow_clr),
    .kb_ready(kb_ready)
  );

  int checks = 0;
  int failures = 0;

  int           pst;
  int           skip;
  bit           kbr;
  bit           movf;
  bit [511:0]   mmap;
  logic [9:0]   q[$];
  bit           rdy;
  bit           clr;
  int           gap;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("evt_valid", evt_valid, q.size() > 0);
    if (q.size() > 0) chk("head", {evt_break, evt_code}, q[0]);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, movf);
    chk("key_down", key_down, mmap);
    chk("kb_ready", kb_ready, kbr);
  endtask

  task automatic model_reset();
    pst  = M_WAIT;
    skip = 0;
    kbr  = 0;
    movf = 0;
    mmap = '0;
    q.delete();
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit e);
    bit         em, eb, dr;
    logic [8:0] ec;
    @(negedge clk);
    byte_valid   = v;
    byte_data    = d;
    byte_err     = e;
    evt_ready    = rdy;
    overflow_clr = clr;
    em = 0; eb = 0; dr = 0; ec = '0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (e) begin
      if (pst != M_WAIT) pst = M_IDLE;
    end else if (v) begin
      case (pst)
        M_WAIT: if (d == 8'hAA) begin pst = M_IDLE; kbr = 1; end
        M_IDLE: begin
          if (d == 8'hE0) pst = M_EXT;
          else if (d == 8'hF0) pst = M_BRK;
          else if (d == 8'hE1) begin pst = M_PAUSE; skip = 7; end
          else if (d == 8'hAA) mmap = '0;
          else if (!(d inside {8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE})) begin
            em = 1; ec = {1'b0, d};
          end
        end
        M_EXT: begin
          if (d == 8'hF0) pst = M_EBRK;
          else if (d != 8'hE0) begin
            em = 1; ec = {1'b1, d}; pst = M_IDLE;
          end
        end
        M_BRK: begin em = 1; eb = 1; ec = {1'b0, d}; pst = M_IDLE; end
        M_EBRK: begin em = 1; eb = 1; ec = {1'b1, d}; pst = M_IDLE; end
        default: begin
          skip--;
          if (skip == 0) begin em = 1; ec = 9'h0E1; pst = M_IDLE; end
        end
      endcase
    end
    if (em && !(FR && !eb && mmap[ec])) begin
      mmap[ec] = !eb;
      if (q.size() < DEPTH) q.push_back({eb, ec});
      else dr = 1;
    end
    if (dr) movf = 1;
    else if (clr) movf = 0;
    @(posedge clk);
    #1;
    byte_valid = 0;
    byte_err   = 0;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0);
    repeat (gap) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    byte_valid   = 0;
    byte_err     = 0;
    byte_data    = 0;
    overflow_clr = 0;
    #1;
    model_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_map", key_down, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_kbr", kb_ready, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] seq6 [8];
  logic [7:0] rb;
  int r;

  initial begin
    rst = 1'b0; byte_valid = 0; byte_err = 0; byte_data = 0;
    evt_ready = 0; overflow_clr = 0;
    rdy = 1; clr = 0; gap = 0;
    do_reset();

    send(8'h1C);
    chk("t1_noevt", evt_valid, 0);
    send(8'hAA);
    chk("t1_kbr", kb_ready, 1);
    send(8'h1C);
    chk("t1_head", {evt_valid, evt_break, evt_code}, {2'b10, 9'h01C});
    chk("t1_kd28", key_down[28], 1);

    send(8'hE0); send(8'h75);
    chk("t2_make", {evt_break, evt_code}, {1'b0, 9'h175});
    chk("t2_kd1", key_down[373], 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_brk", {evt_break, evt_code}, {1'b1, 9'h175});
    chk("t2_kd0", key_down[373], 0);

    send(8'hF0); send(8'h1C); idle(3);
    rdy = 0;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t3_events", fifo_count, 2);
    rdy = 1; idle(4);

    rdy = 0;
    for (int i = 0; i < 9; i++) send(8'h21 + 8'(i));
    chk("t4_count", fifo_count, 8);
    chk("t4_ovf", overflow, 1);
    chk("t4_kd9", key_down[9'h029], 1);
    rdy = 1;
    send(8'h2A);
    chk("t4_full_push", fifo_count, 8);
    idle(10);
    clr = 1; idle(1); clr = 0;
    chk("t4_clr", overflow, 0);

    send(8'hE0);
    idle(TMO + 10);
    pst = M_IDLE;
    send(8'h1C);
    chk("t5_tmo", {evt_break, evt_code}, {1'b0, 9'h01C});
    send(8'hF0); send(8'h1C);
    send(8'hF0);
    cyc(1'b0, 8'h00, 1'b1);
    send(8'h1C);
    chk("t5_err", {evt_break, evt_code}, {1'b0, 9'h01C});

    idle(3);
    rdy = 0;
    seq6 = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq6[i]);
    chk("t6_count", fifo_count, 1);
    chk("t6_pause", {evt_break, evt_code}, {1'b0, 9'h0E1});
    rdy = 1;
    send(8'hE0); send(8'hF0);
    do_reset();

    rdy = 1;
    send(8'hAA);
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) rb = 8'hE0;
      else if (r < 16) rb = 8'hF0;
      else if (r < 19) rb = 8'hE1;
      else if (r < 21) rb = 8'hAA;
      else if (r < 26) rb = 8'hFA;
      else rb = 8'h10 + 8'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) cyc(1'($urandom_range(0, 1)), rb, 1'b1);
      else send(rb);
    end
    clr = 0; rdy = 1; gap = 0;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
